operand_addr_seq: RTL
=====================

// Module: operand_addr_seq
// PURPOSE
//  Addressing-mode sequencer for the 6502 core, directly upstream of address_mux.
//  After decode, it walks the operand and pointer fetch cycles for the instruction's
//  addressing mode and drives address_select on each cycle.
//  It latches operand/pointer bytes from the data bus and applies X/Y indexing into
//  dirl/dirh/indirl/indirh, then holds the effective-address select until execute acks.
// PARAMETERS
//  (none; mode and select encodings are shared constants, see STRUCTURE)
// PORTS
//  clk             in   1  core clock; all state changes on rising edge
//  rst_n           in   1  asynchronous, active-low reset
//  start           in   1  decode has a new instruction; sampled only in IDLE
//  mode            in   4  addressing mode: IMP,IMM,ZP,ZPX,ZPY,ABS,ABSX,ABSY,IND,INDX,INDY
//  data_in         in   8  read data for the address presented this cycle, sampled at clock edge
//  x_reg           in   8  X index register
//  y_reg           in   8  Y index register
//  ack             in   1  execute stage consumed the effective address (READY only)
//  address_select  out  3  to address_mux: 000 PC, 001 zp dirl, 010 dirh:dirl,
//                          011 zp indirl, 100 zp indirl+1, 101 indirh:indirl, 110 indir+1
//  dirl, dirh      out  8  effective-address bytes
//  indirl, indirh  out  8  pointer bytes
//  pc_inc          out  1  1-cycle pulse: advance PC past the byte just fetched
//  busy            out  1  high in every state except IDLE
//  done            out  1  high while in READY (effective address valid)
//  page_cross      out  1  indexed add carried into the high byte (ABSX/ABSY/INDY); held until IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs and registers 0; address_select 000.
//  FSM states: IDLE, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, FIX, READY.
//  - IDLE: select 000. On start, IMP/IMM go to READY; ZP..INDY go to FETCH_LO. Unknown mode is treated as IMP.
//  - FETCH_LO: select 000, pc_inc.
//      ZP/ABS/IND/INDY: latch dirl (or indirl for IND/INDY) = data_in.
//      ZPX/ZPY: dirl = data_in + X/Y, 8-bit wrap, carry ignored.
//      INDX: indirl = data_in + X, 8-bit wrap.
//      ABSX/ABSY: dirl = data_in + idx, carry kept.
//      Next: ZP/ZPX/ZPY -> READY; ABS/ABSX/ABSY/IND -> FETCH_HI; INDX/INDY -> PTR_LO.
//  - FETCH_HI: select 000, pc_inc. Latch dirh (indirh for IND).
//      For ABSX/ABSY, dirh = data_in + carry (see CONFIGURATION).
//      Next: IND -> PTR_LO; others -> READY.
//  - PTR_LO: select 101 (IND) or 011 (INDX/INDY). Latch dirl = data_in (INDY: + Y, carry kept). Next: PTR_HI.
//  - PTR_HI: select 110 (IND, full 16-bit +1, no page-wrap quirk) or 100 (zp wrap).
//      Latch dirh = data_in (INDY: + carry). Next: READY.
//  - READY: done=1. Select: 000 for IMP/IMM, 001 for ZP/ZPX/ZPY, 010 otherwise.
//      Hold until ack, then go to IDLE. IMM pulses pc_inc on the ack cycle.
//  - Registers and select are held stable in READY.
//  - start outside IDLE is ignored, including start coinciding with ack in READY.
//  - ack outside READY is ignored.
//  - rst_n low at any point aborts immediately to the reset state; no partial result is kept.
//  - page_cross = carry out of the low-byte index add; it is 0 for non-indexed modes.
// CONFIGURATION
//  PAGE_CROSS_PENALTY_EN defined: adds 6502-accurate dummy cycle.
//    FETCH_HI/PTR_HI latch the un-carried high byte.
//    If carry, go to FIX: select 010 (dummy read of the wrong page), dirh <= dirh+1, then READY.
//  PAGE_CROSS_PENALTY_EN undefined: FIX is unreachable; the carry is folded in the same cycle.
// STRUCTURE
//  Shared include cpu6502_defs.vh holds:
//    mode codes (IMP=0..INDY=10);
//    address_select codes (SEL_PC..SEL_INDIR_P1);
//    FSM state encodings.
//  It is used by decode, address_mux and this block.
//  One sub-module, index_adder: 8-bit a+b+cin -> sum, cout; instanced for low/high byte adds.
// TESTING
//  1 ABS, bytes 34,12 -> select 000,000 then 010; dirh:dirl=1234; pc_inc x2; done at cycle 3.
//  2 ABSX X=20, bytes F0,12 -> 1310, page_cross=1.
//      Macro off: done at cycle 3.
//      Macro on: FIX presents 1210 with select 010, done at cycle 4.
//  3 ZPX X=10, byte F8 -> dirl=08, select 001, page_cross=0.
//  4 INDY Y=05, byte 40, mem[0040]=FE, mem[0041]=20 -> selects 000,011,100; then 010 = 2103; page_cross=1.
//  5 IND bytes FF,10, mem[10FF]=00, mem[1100]=80 -> selects 000,000,101,110; then 010 = 8000.
//  6 rst_n low during PTR_LO -> next edge: IDLE, all outputs 0.
//    Also: start pulsed while busy changes nothing; ack held low keeps READY and done.

Source files
------------

// File: rtl/operand_addr_seq_pkg.sv
// operand_addr_seq_pkg
//   Constants shared by the addressing-mode sequencer and its neighbours.
//   This package contains the following items:
//   - Addressing-mode codes: IMP=0 .. INDY=10. Codes 11..15 are unused.
//   - address_select codes that are driven to address_mux.
//   - The sequencer FSM state encoding.
//   - Two helpers:
//     - sanitize_mode maps an unknown mode code to IMP.
//     - select_for gives the address_select value that belongs to each state.
package operand_addr_seq_pkg;

  localparam logic [3:0] MODE_IMP  = 4'd0;
  localparam logic [3:0] MODE_IMM  = 4'd1;
  localparam logic [3:0] MODE_ZP   = 4'd2;
  localparam logic [3:0] MODE_ZPX  = 4'd3;
  localparam logic [3:0] MODE_ZPY  = 4'd4;
  localparam logic [3:0] MODE_ABS  = 4'd5;
  localparam logic [3:0] MODE_ABSX = 4'd6;
  localparam logic [3:0] MODE_ABSY = 4'd7;
  localparam logic [3:0] MODE_IND  = 4'd8;
  localparam logic [3:0] MODE_INDX = 4'd9;
  localparam logic [3:0] MODE_INDY = 4'd10;

  localparam logic [2:0] SEL_PC          = 3'b000; // PC
  localparam logic [2:0] SEL_ZP_DIR      = 3'b001; // 00:dirl
  localparam logic [2:0] SEL_DIR         = 3'b010; // dirh:dirl
  localparam logic [2:0] SEL_ZP_INDIR    = 3'b011; // 00:indirl
  localparam logic [2:0] SEL_ZP_INDIR_P1 = 3'b100; // 00:(indirl+1), wraps in page zero
  localparam logic [2:0] SEL_INDIR       = 3'b101; // indirh:indirl
  localparam logic [2:0] SEL_INDIR_P1    = 3'b110; // indirh:indirl + 1, full 16-bit

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH_LO = 3'd1,
    ST_FETCH_HI = 3'd2,
    ST_PTR_LO   = 3'd3,
    ST_PTR_HI   = 3'd4,
    ST_FIX      = 3'd5,
    ST_READY    = 3'd6
  } state_t;

  function automatic logic [3:0] sanitize_mode(input logic [3:0] m);
    return (m > MODE_INDY) ? MODE_IMP : m;
  endfunction

  function automatic logic [2:0] select_for(input state_t st, input logic [3:0] m);
    logic [2:0] sel;
    sel = SEL_PC;
    case (st)
      ST_PTR_LO: sel = (m == MODE_IND) ? SEL_INDIR : SEL_ZP_INDIR;
      ST_PTR_HI: sel = (m == MODE_IND) ? SEL_INDIR_P1 : SEL_ZP_INDIR_P1;
      ST_FIX:    sel = SEL_DIR;
      ST_READY: begin
        if (m == MODE_IMP || m == MODE_IMM) begin
          sel = SEL_PC;
        end else if (m == MODE_ZP || m == MODE_ZPX || m == MODE_ZPY) begin
          sel = SEL_ZP_DIR;
        end else begin
          sel = SEL_DIR;
        end
      end
      default: sel = SEL_PC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/operand_addr_seq_index.sv
// index_adder
//   This module is an 8-bit adder with carry in and carry out.
//   The sequencer uses it for two adds:
//   - the low-byte index add;
//   - the high-byte carry fold.
// Ports
//   a, b  in   8  addends
//   cin   in   1  carry in
//   sum   out  8  (a + b + cin) mod 256
//   cout  out  1  carry out of bit 7
module index_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'h00, cin};

endmodule

// File: rtl/operand_addr_seq.sv
// operand_addr_seq
//   This block is the addressing-mode sequencer of the 6502 core. It sits directly upstream of address_mux.
//   After decode it performs the operand fetch cycles and the pointer fetch cycles for the addressing mode.
//   It latches the fetched bytes and applies X or Y indexing.
//   It then holds the effective-address select until the execute stage acknowledges it.
//
// Configuration macro: PAGE_CROSS_PENALTY_EN
//   - When defined, an indexed add that carries into the high byte costs one extra FIX cycle.
//     During FIX the un-carried address (the dummy read of the wrong page) is presented with select 010.
//     The high byte is incremented at the end of that cycle.
//   - When undefined, the carry is folded into the high byte in the same cycle that latches it.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            in   new instruction from decode; sampled only in IDLE
//   mode[3:0]        in   addressing mode (IMP..INDY, codes 11..15 act as IMP)
//   data_in[7:0]     in   read data for the address presented this cycle
//   x_reg, y_reg     in   index registers
//   ack              in   execute consumed the effective address; honoured only in READY
//   address_select   out  address_mux select for the current cycle
//   dirl, dirh       out  effective-address bytes
//   indirl, indirh   out  pointer bytes
//   pc_inc           out  advance PC past the byte fetched this cycle
//   busy             out  high in every state but IDLE
//   done             out  high in READY
//   page_cross       out  the indexed low-byte add carried (ABSX/ABSY/INDY); held until IDLE
//   state_dbg        out  current FSM state, for observation only
//
// Handshake:
//   - start is a request that is taken only when the block is IDLE. Any start seen while busy is ignored.
//   - done acts as "valid" for the effective address.
//   - ack is the consumer's "ready". The address is consumed on the clock edge where done and ack are both high.
//   - ack is ignored at any other time.
module operand_addr_seq
  import operand_addr_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mode,
  input  logic [7:0] data_in,
  input  logic [7:0] x_reg,
  input  logic [7:0] y_reg,
  input  logic       ack,
  output logic [2:0] address_select,
  output logic [7:0] dirl,
  output logic [7:0] dirh,
  output logic [7:0] indirl,
  output logic [7:0] indirh,
  output logic       pc_inc,
  output logic       busy,
  output logic       done,
  output logic       page_cross,
  output state_t     state_dbg
);

  state_t     state;
  state_t     next_state;
  logic [3:0] mode_q;
  logic [3:0] mode_next;
  logic       pc_inc_q;

  logic [7:0] lo_idx;
  logic [7:0] lo_sum;
  logic       lo_cout;
  logic [7:0] hi_a;
  logic       hi_cin;
  logic [7:0] hi_sum;
  logic       hi_cout_unused;

  // Low-byte add: the index applies to the operand byte for ZPX/ZPY/ABSX/ABSY/INDX.
  // It applies to the pointer's low byte for INDY. Every other latch adds 0.
  always_comb begin
    lo_idx = 8'h00;
    if (state == ST_FETCH_LO) begin
      case (mode_q)
        MODE_ZPX, MODE_ABSX, MODE_INDX: lo_idx = x_reg;
        MODE_ZPY, MODE_ABSY:            lo_idx = y_reg;
        default:                        lo_idx = 8'h00;
      endcase
    end else if (state == ST_PTR_LO && mode_q == MODE_INDY) begin
      lo_idx = y_reg;
    end
  end

  index_adder u_lo_add (
    .a    (data_in),
    .b    (lo_idx),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // High-byte add.
  // page_cross is the low-byte carry and is 0 for non-indexed modes.
  // The same adder serves FETCH_HI, PTR_HI and FIX for every mode.
  always_comb begin
    hi_a = (state == ST_FIX) ? dirh : data_in;
`ifdef PAGE_CROSS_PENALTY_EN
    hi_cin = (state == ST_FIX);
`else
    hi_cin = page_cross;
`endif
  end

  index_adder u_hi_add (
    .a    (hi_a),
    .b    (8'h00),
    .cin  (hi_cin),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  always_comb begin
    next_state = state;
    mode_next  = mode_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          mode_next = sanitize_mode(mode);
          if (mode_next == MODE_IMP || mode_next == MODE_IMM) begin
            next_state = ST_READY;
          end else begin
            next_state = ST_FETCH_LO;
          end
        end
      end
      ST_FETCH_LO: begin
        case (mode_q)
          MODE_ZP, MODE_ZPX, MODE_ZPY:               next_state = ST_READY;
          MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND:  next_state = ST_FETCH_HI;
          default:                                   next_state = ST_PTR_LO;
        endcase
      end
      ST_FETCH_HI: begin
        if (mode_q == MODE_IND) begin
          next_state = ST_PTR_LO;
`ifdef PAGE_CROSS_PENALTY_EN
        end else if (page_cross) begin
          next_state = ST_FIX;
`endif
        end else begin
          next_state = ST_READY;
        end
      end
      ST_PTR_LO: next_state = ST_PTR_HI;
      ST_PTR_HI: begin
`ifdef PAGE_CROSS_PENALTY_EN
        next_state = page_cross ? ST_FIX : ST_READY;
`else
        next_state = ST_READY;
`endif
      end
      ST_FIX:   next_state = ST_READY;
      ST_READY: if (ack) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The outputs are registered from next_state. This way address_select, busy and done
  // always describe the state the block is in during the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mode_q         <= MODE_IMP;
      address_select <= SEL_PC;
      dirl           <= 8'h00;
      dirh           <= 8'h00;
      indirl         <= 8'h00;
      indirh         <= 8'h00;
      pc_inc_q       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      page_cross     <= 1'b0;
    end else begin
      state          <= next_state;
      mode_q         <= mode_next;
      address_select <= select_for(next_state, mode_next);
      busy           <= (next_state != ST_IDLE);
      done           <= (next_state == ST_READY);
      pc_inc_q       <= (next_state == ST_FETCH_LO) || (next_state == ST_FETCH_HI);
      case (state)
        ST_IDLE: begin
          if (start) page_cross <= 1'b0;
        end
        ST_FETCH_LO: begin
          if (mode_q == MODE_IND || mode_q == MODE_INDX || mode_q == MODE_INDY) begin
            indirl <= lo_sum;
          end else begin
            dirl <= lo_sum;
          end
          if (mode_q == MODE_ABSX || mode_q == MODE_ABSY) page_cross <= lo_cout;
        end
        ST_FETCH_HI: begin
          if (mode_q == MODE_IND) begin
            indirh <= data_in;
          end else begin
            dirh <= hi_sum;
          end
        end
        ST_PTR_LO: begin
          dirl <= lo_sum;
          if (mode_q == MODE_INDY) page_cross <= lo_cout;
        end
        ST_PTR_HI: dirh <= hi_sum;
        ST_FIX:    dirh <= hi_sum;
        ST_READY: begin
          if (ack) page_cross <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // IMM consumes its operand byte at the moment execute takes it.
  // For that reason its PC advance follows ack in the same cycle, not a registered state.
  assign pc_inc    = pc_inc_q | ((state == ST_READY) && (mode_q == MODE_IMM) && ack);
  assign state_dbg = state;

endmodule
